div_result_fifo: RTL
====================

Name: div_result_fifo

Overview:
- Downstream consumer of the pipelined array divider.
- The divider has no backpressure: once an operand pair is issued, a result appears a fixed number of cycles later, whatever the consumer is doing.
- This block captures every divider result (o_valid, Q_out, R_out) into a FIFO and presents it on a valid/ready interface.
- It also tracks in-flight operations and drives a credit signal (can_issue) to the issuing logic, so a result never arrives at a full FIFO.

Parameters:
- DATAWIDTH, 4, width of quotient and remainder; must match the divider instance.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and in-flight counters (localparam-derived, not overridable).

Ports:
- clk  input  1  rising-edge clock shared with the divider.
- rst  input  1  synchronous active-high reset.
- issue  input  1  high in a cycle where upstream drives divider i_valid=1 (same signal, tapped).
- div_o_valid  input  1  divider o_valid.
- div_q  input  DATAWIDTH  divider Q_out.
- div_r  input  DATAWIDTH  divider R_out.
- can_issue  output  1  credit available; upstream may assert issue only when this is high.
- m_valid  output  1  head entry valid.
- m_ready  input  1  consumer accepts the head entry.
- m_q  output  DATAWIDTH  head quotient; 0 when m_valid=0.
- m_r  output  DATAWIDTH  head remainder; 0 when m_valid=0.
- occupancy  output  CNT_W  entries currently stored.
- inflight  output  CNT_W  issued operations not yet returned.
- err_overflow  output  1  sticky; a result arrived while the FIFO was full.
- err_credit  output  1  sticky; issue was asserted while can_issue=0.

Behaviour:
- Reset (synchronous, at the clk edge while rst=1) clears:
  - rd_ptr, wr_ptr, occupancy, inflight to 0
  - m_valid, m_q, m_r, err_overflow, err_credit to 0
  - can_issue becomes 1 in the cycle after reset deasserts.
- A reset mid-operation discards stored and in-flight results. Divider results arriving after reset are still pushed, because the divider pipeline is not reset by this block; the integration reset must cover both blocks.
- Push: at a clk edge where div_o_valid=1 and occupancy<DEPTH, write {div_q, div_r} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Pop: at a clk edge where m_valid=1 and m_ready=1, advance rd_ptr; rd_ptr wraps DEPTH-1 -> 0.
- m_valid = (occupancy != 0). m_q/m_r read combinationally from mem[rd_ptr] and are gated to 0 when m_valid=0.
- Simultaneous push and pop:
  - Allowed, including when full: a pop frees the slot in the same edge, so the push is accepted and occupancy is unchanged.
  - When empty: see Optional Feature.
- Overflow: div_o_valid=1, occupancy==DEPTH and no pop in that cycle -> result dropped, err_overflow set. It stays set until reset.
- inflight: +1 on issue, -1 on div_o_valid; both together -> unchanged. Saturates at 0 on an underflow (spurious o_valid).
- can_issue = (occupancy + inflight) < DEPTH; combinational from registered counters.
  - A pop in the current cycle does not raise can_issue until the next cycle (conservative).
- err_credit: set when issue=1 while can_issue=0; sticky. The issue is still counted in inflight.
- Latency: result captured to m_valid=1 is 1 cycle. No dependence on divider pipeline depth, since credits are counted from issue to return.
- Arithmetic: the occupancy + inflight sum is computed at CNT_W+1 bits to avoid wrap.

Optional Feature:
- Macro: DIV_RESULT_FIFO_BYPASS_EN.
- Defined, empty FIFO (occupancy=0), div_o_valid=1:
  - m_valid=1 combinationally, with m_q/m_r = div_q/div_r.
  - If m_ready=1 in that cycle, nothing is written and occupancy stays 0.
  - If m_ready=0, the result is written normally.
- Not defined: an empty FIFO always writes first; m_valid rises the next cycle (1-cycle latency).
- Credit accounting is identical in both builds.

Test Plan:
- Reset then idle -> m_valid=0, m_q=m_r=0, occupancy=0, inflight=0, can_issue=1, both err flags 0.
- DEPTH=8; issue 8 ops in consecutive cycles, m_ready=0 -> can_issue falls after the 8th issue; results Q=3,R=1 etc. stored in order; occupancy=8, inflight=0.
- Full FIFO; pop and div_o_valid together (Q=5,R=2) -> occupancy stays 8, entry appended, err_overflow=0.
- Full FIFO, m_ready=0, force div_o_valid=1 -> result dropped, err_overflow=1 and held until rst.
- Issue while can_issue=0 -> err_credit=1, inflight increments.
- Run 20 random issue/m_ready cycles to force pointer wrap -> output order matches issue order. With BYPASS_EN, an empty-FIFO result with m_ready=1 is seen at m_q in the same cycle and occupancy stays 0.

Source files
------------

// File: rtl/div_result_fifo.sv
// Result FIFO and issue-credit tracker behind the pipelined array divider.
// Optional same-cycle bypass on an empty FIFO: define DIV_RESULT_FIFO_BYPASS_EN.
module div_result_fifo #(
    parameter  int DATAWIDTH = 4,
    parameter  int DEPTH     = 8,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  logic                 div_o_valid,
    input  logic [DATAWIDTH-1:0] div_q,
    input  logic [DATAWIDTH-1:0] div_r,
    output logic                 can_issue,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATAWIDTH-1:0] m_q,
    output logic [DATAWIDTH-1:0] m_r,
    output logic [CNT_W-1:0]     occupancy,
    output logic [CNT_W-1:0]     inflight,
    output logic                 err_overflow,
    output logic                 err_credit
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   CRED_LIM = (CNT_W + 1)'(DEPTH);

    logic [2*DATAWIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_occ;
    logic [CNT_W-1:0]       r_infl;
    logic                   r_err_ovf;
    logic                   r_err_cred;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_m_valid;
    logic [2*DATAWIDTH-1:0] w_head;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [CNT_W:0]         w_sum;

    assign w_full  = (r_occ == FULL_CNT);
    assign w_empty = (r_occ == '0);

    always_comb begin
        w_m_valid = 1'b0;
        w_head    = r_mem[r_rd_ptr];
        w_pop     = 1'b0;
        w_push    = 1'b0;
`ifdef DIV_RESULT_FIFO_BYPASS_EN
        // An empty FIFO shows the arriving result directly; a taken bypass skips the write.
        w_m_valid = !w_empty || div_o_valid;
        if (w_empty)
            w_head = {div_q, div_r};
        w_pop  = !w_empty && m_ready;
        w_push = div_o_valid && (!w_full || w_pop)
               && !(w_empty && m_ready);
`else
        w_m_valid = !w_empty;
        w_pop     = w_m_valid && m_ready;
        w_push    = div_o_valid && (!w_full || w_pop);
`endif
    end

    assign w_drop = div_o_valid && w_full && !w_pop;
    assign w_sum  = {1'b0, r_occ} + {1'b0, r_infl};

    assign can_issue    = (w_sum < CRED_LIM);
    assign m_valid      = w_m_valid;
    assign m_q          = w_m_valid ? w_head[2*DATAWIDTH-1:DATAWIDTH] : '0;
    assign m_r          = w_m_valid ? w_head[DATAWIDTH-1:0] : '0;
    assign occupancy    = r_occ;
    assign inflight     = r_infl;
    assign err_overflow = r_err_ovf;
    assign err_credit   = r_err_cred;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {div_q, div_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_occ      <= '0;
            r_infl     <= '0;
            r_err_ovf  <= 1'b0;
            r_err_cred <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_occ <= r_occ + 1'b1;
            else if (w_pop && !w_push)
                r_occ <= r_occ - 1'b1;
            // A spurious return with nothing in flight leaves the count at zero.
            if (issue && !div_o_valid)
                r_infl <= r_infl + 1'b1;
            else if (div_o_valid && !issue && r_infl != '0)
                r_infl <= r_infl - 1'b1;
            if (w_drop)
                r_err_ovf <= 1'b1;
            if (issue && !can_issue)
                r_err_cred <= 1'b1;
        end
    end

endmodule
